// File: rtl/mult8x8_seq_core.sv
// Sequencing/accumulation core of the 8x8 sequential multiplier: one 4x4 nibble
// partial product per step, shifted and summed into a 16-bit accumulator.
module mult8x8_seq_core (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  input  logic [1:0]  count,
  output logic        cnt_clr_n,
  output logic [15:0] product,
  output logic        done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE, ERR} state_t;

  state_t      state, state_nx;
  logic [7:0]  a_q, b_q, a_nx, b_nx;
  logic [1:0]  step, step_nx;
  logic [15:0] prod_nx;
  logic        done_nx, busy_nx, err_nx, clr_nx;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_sh;

  // count[1] picks the multiplicand nibble, count[0] the multiplier nibble
  always_comb begin
    nib_a = count[1] ? a_q[7:4] : a_q[3:0];
    nib_b = count[0] ? b_q[7:4] : b_q[3:0];
    pp    = {4'd0, nib_a} * {4'd0, nib_b};
    case (count)
      2'd0:    pp_sh = {8'd0, pp};
      2'd3:    pp_sh = {pp, 8'd0};
      default: pp_sh = {4'd0, pp, 4'd0};
    endcase
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    step_nx  = step;
    prod_nx  = product;
    done_nx  = done;
    busy_nx  = busy;
    err_nx   = err;
    clr_nx   = cnt_clr_n;
    case (state)
      CALC: begin
        if (count != step) begin
          // counter out of lock: abandon the operation, keep the partial sum
          state_nx = ERR;
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          clr_nx   = 1'b0;
        end else begin
          prod_nx = product + pp_sh;
          step_nx = step + 2'd1;
          if (step == 2'd3) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            clr_nx   = 1'b0;
          end
        end
      end
      default: begin
        clr_nx = 1'b0;
        if (start) begin
          state_nx = CALC;
          a_nx     = dataa;
          b_nx     = datab;
          prod_nx  = 16'd0;
          step_nx  = 2'd0;
          clr_nx   = 1'b1;
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= IDLE;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      step      <= 2'd0;
      product   <= 16'd0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cnt_clr_n <= 1'b0;
    end else begin
      state     <= state_nx;
      a_q       <= a_nx;
      b_q       <= b_nx;
      step      <= step_nx;
      product   <= prod_nx;
      done      <= done_nx;
      busy      <= busy_nx;
      err       <= err_nx;
      cnt_clr_n <= clr_nx;
    end
  end

endmodule

// File: tb/tb_mult8x8_seq_core.sv
// Directed bench for mult8x8_seq_core with a 2-bit step counter model attached
// (clearable by the core, overridable to inject a count error).
module tb_mult8x8_seq_core;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        start;
  logic [7:0]  dataa, datab;
  logic [1:0]  count;
  logic        cnt_clr_n;
  logic [15:0] product;
  logic        done, busy, err;

  logic [1:0]  cnt_q;
  logic        frc_en;
  logic [1:0]  frc_val;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge cnt_clr_n)
    if (!cnt_clr_n) cnt_q <= 2'd0;
    else            cnt_q <= cnt_q + 2'd1;

  assign count = frc_en ? frc_val : cnt_q;

  mult8x8_seq_core dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .start     (start),
    .dataa     (dataa),
    .datab     (datab),
    .count     (count),
    .cnt_clr_n (cnt_clr_n),
    .product   (product),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int gap, busy_cyc, done_cnt;
  logic [7:0]  op_a [3];
  logic [7:0]  op_b [3];
  logic [15:0] op_p [3];

  initial begin
    aclr_n = 1'b0; start = 1'b0; dataa = 8'd0; datab = 8'd0;
    frc_en = 1'b0; frc_val = 2'd0;

    // reset while idle
    #12;
    chk("rst_product", product, 16'h0000);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_clr", {15'd0, cnt_clr_n}, 16'd0);
    aclr_n = 1'b1;
    tick(2);

    // 0xFF * 0xFF, single start pulse
    dataa = 8'hFF; datab = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0; dataa = 8'h00; datab = 8'h00;
    chk("ff_clr_rise", {15'd0, cnt_clr_n}, 16'd1);
    busy_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_cyc++;
      tick();
    end
    chk("ff_busy_cycles", busy_cyc[15:0], 16'd4);
    chk("ff_product", product, 16'hFE01);
    chk("ff_done", {15'd0, done}, 16'd1);
    chk("ff_busy_end", {15'd0, busy}, 16'd0);
    chk("ff_clr_end", {15'd0, cnt_clr_n}, 16'd0);
    tick();
    chk("ff_hold", product, 16'hFE01);
    chk("ff_done_hold", {15'd0, done}, 16'd1);

    // back-to-back with start held high
    op_a = '{8'h12, 8'hA5, 8'h80};
    op_b = '{8'h34, 8'h00, 8'h02};
    op_p = '{16'h03A8, 16'h0000, 16'h0100};
    dataa = op_a[0]; datab = op_b[0]; start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      while (!done && gap < 12) begin
        gap++;
        tick();
      end
      chk($sformatf("b2b_gap%0d", k), gap[15:0], 16'd4);
      chk($sformatf("b2b_prod%0d", k), product, op_p[k]);
      if (k < 2) begin
        dataa = op_a[k+1]; datab = op_b[k+1];
      end else begin
        start = 1'b0;
      end
      tick();
    end

    // start re-pulsed mid-operation is ignored
    dataa = 8'h0F; datab = 8'hF0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dataa = 8'hFF; datab = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    chk("ign_product", product, 16'h0E10);
    chk("ign_done", {15'd0, done}, 16'd1);

    // injected count error at the second step
    dataa = 8'h21; datab = 8'h43; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    frc_en = 1'b1; frc_val = 2'd2;
    tick();
    frc_en = 1'b0;
    tick();
    chk("err_flag", {15'd0, err}, 16'd1);
    chk("err_busy", {15'd0, busy}, 16'd0);
    chk("err_clr", {15'd0, cnt_clr_n}, 16'd0);
    chk("err_done", {15'd0, done}, 16'd0);
    chk("err_product", product, 16'h0003);
    tick(2);
    chk("err_sticky", {15'd0, err}, 16'd1);
    chk("err_frozen", product, 16'h0003);
    dataa = 8'h03; datab = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared", {15'd0, err}, 16'd0);
    tick(4);
    chk("err_recover", product, 16'h000F);
    chk("err_recover_done", {15'd0, done}, 16'd1);

    // async reset mid-operation
    dataa = 8'hFF; datab = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    #2 aclr_n = 1'b0;
    #1;
    chk("arst_product", product, 16'h0000);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_clr", {15'd0, cnt_clr_n}, 16'd0);
    start = 1'b1;
    tick();
    chk("arst_start_blocked", {15'd0, busy}, 16'd0);
    start = 1'b0;
    #2 aclr_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("arst_no_done", done_cnt[15:0], 16'd0);
    dataa = 8'h03; datab = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    chk("arst_recover", product, 16'h000F);
    chk("arst_recover_done", {15'd0, done}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
